s32x_vdp_bus_master: RTL and testbench

Bus initiator for the 32X VDP register, frame-buffer and palette ports. It converts a single-word request (from the SH2 bridge or a test DMA) into the VDP's chip-select/strobe/ACK_N handshake, then returns read data, completion and an error flag. It is the other end of the VDP's slave interface and drives `REG_CS_N`, `DRAM_CS_N`, `PAL_CS_N`, `RD_N`, `LWR_N`, `UWR_N` and `A`, while sampling `ACK_N` and the VDP's data output.

---
 rtl/s32x_vdp_bus_master.sv | 163 ++++++++++++++++
 tb/tb_s32x_vdp_bus_master.sv | 370 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/s32x_vdp_bus_master.sv
// Bus initiator for the 32X VDP slave port: turns one word request into the
// chip-select / strobe / ACK_N handshake and reports read data, completion and error.
module s32x_vdp_bus_master #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_req,
  input  logic        i_we,
  input  logic [1:0]  i_space,
  input  logic [16:0] i_addr,
  input  logic [15:0] i_wdata,
  input  logic [1:0]  i_be,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_err,
  output logic [15:0] o_rdata,
  output logic [16:0] o_a,
  output logic [15:0] o_do,
  input  logic [15:0] i_di,
  output logic        o_rd_n,
  output logic        o_lwr_n,
  output logic        o_uwr_n,
  output logic        o_reg_cs_n,
  output logic        o_dram_cs_n,
  output logic        o_pal_cs_n,
  input  logic        i_ack_n
);

  typedef enum logic [2:0] {StIdle, StSetup, StStrobe, StRelease, StDone} state_e;

  localparam logic [7:0] TimeoutVal = 8'(TIMEOUT);

  state_e      r_state;
  state_e      w_next_state;
  logic        r_we;
  logic [1:0]  r_space;
  logic [1:0]  r_be;
  logic [16:0] r_addr;
  logic [15:0] r_wdata;
  logic [15:0] r_rdata;
  logic        r_err;
  logic [7:0]  r_cnt;

  logic       w_accept;
  logic       w_reject;
  logic [7:0] w_cnt_plus;
  logic       w_expire;
  logic       w_cnt_clr;
  logic       w_cnt_inc;
  logic       w_set_err;
  logic       w_capture;
  logic       w_cs_act;
  logic       w_strobe;

  assign w_accept   = i_req && (r_state == StIdle);
  // Palette only takes full-word writes; reserved space and empty writes never reach the bus.
  assign w_reject   = (i_space == 2'd3) || (i_we && (i_be == 2'b00)) ||
                      (i_we && (i_space == 2'd2) && (i_be != 2'b11));
  assign w_cnt_plus = r_cnt + 8'd1;
  assign w_expire   = (w_cnt_plus == TimeoutVal);

  always_comb begin
    w_next_state = r_state;
    w_cnt_clr    = 1'b0;
    w_cnt_inc    = 1'b0;
    w_set_err    = 1'b0;
    w_capture    = 1'b0;
    case (r_state)
      StIdle: begin
        w_cnt_clr = 1'b1;
        if (w_accept) w_next_state = w_reject ? StDone : StSetup;
      end
      StSetup: begin
        if (i_ack_n) begin
          w_next_state = StStrobe;
          w_cnt_clr    = 1'b1;
        end else if (w_expire) begin
          w_next_state = StRelease;
          w_set_err    = 1'b1;
          w_cnt_clr    = 1'b1;
        end else begin
          w_cnt_inc = 1'b1;
        end
      end
      StStrobe: begin
        // A sampled ack wins over a simultaneous timeout.
        if (!i_ack_n) begin
          w_next_state = StRelease;
          w_capture    = !r_we;
          w_cnt_clr    = 1'b1;
        end else if (w_expire) begin
          w_next_state = StRelease;
          w_set_err    = 1'b1;
          w_cnt_clr    = 1'b1;
        end else begin
          w_cnt_inc = 1'b1;
        end
      end
      StRelease: begin
        if (i_ack_n) begin
          w_next_state = StDone;
        end else if (w_expire) begin
          w_next_state = StDone;
          w_set_err    = 1'b1;
        end else begin
          w_cnt_inc = 1'b1;
        end
      end
      StDone:  w_next_state = StIdle;
      default: w_next_state = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= StIdle;
      r_we    <= 1'b0;
      r_space <= 2'd0;
      r_be    <= 2'd0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next_state;
      if (w_accept) begin
        r_we    <= i_we;
        r_space <= i_space;
        r_be    <= i_be;
        r_addr  <= i_addr;
        r_wdata <= i_wdata;
        r_err   <= w_reject;
      end else if (w_set_err) begin
        r_err <= 1'b1;
      end
      if (w_cnt_clr) begin
        r_cnt <= '0;
      end else if (w_cnt_inc) begin
        r_cnt <= w_cnt_plus;
      end
      if (w_capture) r_rdata <= i_di;
    end
  end

  assign w_cs_act = (r_state == StSetup) || (r_state == StStrobe);
  assign w_strobe = (r_state == StStrobe);

  assign o_reg_cs_n  = !(w_cs_act && (r_space == 2'd0));
  assign o_dram_cs_n = !(w_cs_act && (r_space == 2'd1));
  assign o_pal_cs_n  = !(w_cs_act && (r_space == 2'd2));
  assign o_rd_n      = !(w_strobe && !r_we);
  assign o_lwr_n     = !(w_strobe && r_we && r_be[0]);
  assign o_uwr_n     = !(w_strobe && r_we && r_be[1]);
  assign o_a         = r_addr;
  assign o_do        = r_wdata;
  assign o_rdata     = r_rdata;
  assign o_busy      = (r_state != StIdle);
  assign o_done      = (r_state == StDone);
  assign o_err       = r_err && (r_state == StDone);

endmodule

// File: tb/tb_s32x_vdp_bus_master.sv
// Bench for s32x_vdp_bus_master: directed vector table, random requests against a
// request-level model, and hand sequences for stale ack, reset and back-to-back requests.
module tb_s32x_vdp_bus_master;

  localparam int unsigned TO = 4;

  logic        clk;
  logic        rst;
  logic        req;
  logic        we;
  logic [1:0]  space;
  logic [16:0] addr;
  logic [15:0] wdata;
  logic [1:0]  be;
  logic        busy;
  logic        done;
  logic        err;
  logic [15:0] rdata;
  logic [16:0] bus_a;
  logic [15:0] bus_do;
  logic [15:0] bus_di;
  logic        rd_n;
  logic        lwr_n;
  logic        uwr_n;
  logic        reg_cs_n;
  logic        dram_cs_n;
  logic        pal_cs_n;
  logic        ack_n;

  int          resp_mode;  // 0: ack while strobe seen, 1: withhold ack, 2: hold ack low
  logic [15:0] resp_di;
  int          n_checks;
  int          n_fail;
  logic [15:0] model_rdata;

  s32x_vdp_bus_master #(.TIMEOUT(TO)) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_req      (req),
    .i_we       (we),
    .i_space    (space),
    .i_addr     (addr),
    .i_wdata    (wdata),
    .i_be       (be),
    .o_busy     (busy),
    .o_done     (done),
    .o_err      (err),
    .o_rdata    (rdata),
    .o_a        (bus_a),
    .o_do       (bus_do),
    .i_di       (bus_di),
    .o_rd_n     (rd_n),
    .o_lwr_n    (lwr_n),
    .o_uwr_n    (uwr_n),
    .o_reg_cs_n (reg_cs_n),
    .o_dram_cs_n(dram_cs_n),
    .o_pal_cs_n (pal_cs_n),
    .i_ack_n    (ack_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model VDP: acks on the first edge it sees a strobe, releases once the strobe is gone.
  always @(posedge clk) begin
    if (rst) ack_n <= 1'b1;
    else if (resp_mode == 0) ack_n <= rd_n & lwr_n & uwr_n;
    else if (resp_mode == 1) ack_n <= 1'b1;
    else ack_n <= 1'b0;
  end
  assign bus_di = resp_di;

  typedef struct {
    logic        we;
    logic [1:0]  space;
    logic [16:0] addr;
    logic [15:0] wdata;
    logic [1:0]  be;
    logic [15:0] di;
    int          mode;
    logic        exp_err;
    logic [15:0] exp_rdata;
    int          exp_k;    // edges after accept edge until DONE is visible
    logic        exp_bus;  // any select/strobe activity expected
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic run_txn(input vec_t v, input string tag);
    logic viol;
    logic strobe_seen;
    logic prev_cs;
    logic saw_done;
    logic err_seen;
    logic str_low;
    logic [2:0] cs_low;
    logic [2:0] cs_exp;
    int k;
    int cs_cnt;
    viol = 1'b0;
    strobe_seen = 1'b0;
    prev_cs = 1'b0;
    saw_done = 1'b0;
    err_seen = 1'b0;
    k = -1;
    cs_exp = 3'b001 << v.space;
    resp_mode = v.mode;
    resp_di = v.di;
    @(negedge clk);
    req = 1'b1;
    we = v.we;
    space = v.space;
    addr = v.addr;
    wdata = v.wdata;
    be = v.be;
    @(posedge clk);
    #1;
    req = 1'b0;
    we = 1'($urandom);
    space = 2'($urandom);
    addr = 17'($urandom);
    wdata = 16'($urandom);
    be = 2'($urandom);
    for (int c = 0; c < 40; c++) begin
      cs_low = {!pal_cs_n, !dram_cs_n, !reg_cs_n};
      cs_cnt = int'(cs_low[0]) + int'(cs_low[1]) + int'(cs_low[2]);
      str_low = !rd_n || !lwr_n || !uwr_n;
      if (!busy) viol = 1'b1;
      if (cs_cnt > 1 || (!v.exp_bus && cs_cnt != 0)) viol = 1'b1;
      if (cs_cnt == 1 && cs_low != cs_exp) viol = 1'b1;
      if (str_low) begin
        if (!prev_cs || cs_cnt != 1 || bus_a != v.addr) viol = 1'b1;
        if (v.we) begin
          if (bus_do != v.wdata || lwr_n != !v.be[0] || uwr_n != !v.be[1] || !rd_n) viol = 1'b1;
        end else if (rd_n || !lwr_n || !uwr_n) begin
          viol = 1'b1;
        end
        strobe_seen = 1'b1;
      end
      prev_cs = (cs_cnt == 1);
      if (done) begin
        saw_done = 1'b1;
        k = c;
        err_seen = err;
        break;
      end
      @(posedge clk);
      #1;
    end
    check({tag, " done seen"}, 32'(saw_done), 32'd1);
    if (saw_done) begin
      check({tag, " latency"}, 32'(k), 32'(v.exp_k));
      check({tag, " err"}, 32'(err_seen), 32'(v.exp_err));
    end
    check({tag, " rdata"}, 32'(rdata), 32'(v.exp_rdata));
    check({tag, " strobe seen"}, 32'(strobe_seen), 32'(v.exp_bus));
    check({tag, " bus rules"}, 32'(viol), 32'd0);
    @(posedge clk);
    #1;
    check({tag, " idle after"}, 32'({busy, done}), 32'd0);
    resp_mode = 0;
  endtask

  vec_t tbl[10];
  vec_t rv;
  logic rej;
  logic seen;
  int   kk;

  initial begin
    n_checks = 0;
    n_fail = 0;
    resp_mode = 0;
    resp_di = 16'h0;
    rst = 1'b1;
    req = 1'b0;
    we = 1'b0;
    space = 2'd0;
    addr = '0;
    wdata = '0;
    be = 2'b00;
    model_rdata = 16'h0;

    //          we    sp     addr       wdata     be     di        md ee    rdata     k  bus
    tbl[0] = '{1'b0, 2'd0, 17'h00005, 16'h0000, 2'b11, 16'h1234, 0, 1'b0, 16'h1234, 5, 1'b1};
    tbl[1] = '{1'b1, 2'd1, 17'h1ABCD, 16'hABCD, 2'b01, 16'hFFFF, 0, 1'b0, 16'h1234, 5, 1'b1};
    tbl[2] = '{1'b1, 2'd2, 17'h00010, 16'h0E0E, 2'b10, 16'hFFFF, 0, 1'b1, 16'h1234, 0, 1'b0};
    tbl[3] = '{1'b1, 2'd2, 17'h00010, 16'h0E0E, 2'b11, 16'hFFFF, 0, 1'b0, 16'h1234, 5, 1'b1};
    tbl[4] = '{1'b0, 2'd1, 17'h00100, 16'h0000, 2'b11, 16'hDEAD, 1, 1'b1, 16'h1234, 6, 1'b1};
    tbl[5] = '{1'b0, 2'd3, 17'h00002, 16'h0000, 2'b11, 16'hBEEF, 0, 1'b1, 16'h1234, 0, 1'b0};
    tbl[6] = '{1'b1, 2'd0, 17'h00003, 16'h5555, 2'b00, 16'hBEEF, 0, 1'b1, 16'h1234, 0, 1'b0};
    tbl[7] = '{1'b0, 2'd2, 17'h000FF, 16'h0000, 2'b00, 16'h0F0F, 0, 1'b0, 16'h0F0F, 5, 1'b1};
    tbl[8] = '{1'b1, 2'd1, 17'h0F00F, 16'h8421, 2'b10, 16'h1111, 0, 1'b0, 16'h0F0F, 5, 1'b1};
    tbl[9] = '{1'b1, 2'd0, 17'h00001, 16'hC3C3, 2'b11, 16'h2222, 0, 1'b0, 16'h0F0F, 5, 1'b1};

    repeat (3) @(posedge clk);
    #1;
    check("reset n_outputs", 32'({rd_n, lwr_n, uwr_n, reg_cs_n, dram_cs_n, pal_cs_n}), 32'h3F);
    check("reset busy/done/err", 32'({busy, done, err}), 32'd0);
    check("reset rdata", 32'(rdata), 32'd0);
    check("reset a/do", 32'(bus_a) | 32'(bus_do), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 10; i++) begin
      run_txn(tbl[i], $sformatf("vec%0d", i));
      model_rdata = tbl[i].exp_rdata;
    end

    // Random requests against the request-level model.
    for (int i = 0; i < 40; i++) begin
      rv.we = 1'($urandom);
      rv.space = 2'($urandom);
      rv.addr = 17'($urandom);
      rv.wdata = 16'($urandom);
      rv.be = 2'($urandom);
      rv.di = 16'($urandom);
      rv.mode = ($urandom_range(0, 3) == 0) ? 1 : 0;
      rej = (rv.space == 2'd3) || (rv.we && rv.be == 2'b00) ||
            (rv.we && rv.space == 2'd2 && rv.be != 2'b11);
      if (rej) begin
        rv.exp_err = 1'b1;
        rv.exp_k = 0;
        rv.exp_bus = 1'b0;
      end else if (rv.mode == 1) begin
        rv.exp_err = 1'b1;
        rv.exp_k = int'(TO) + 2;
        rv.exp_bus = 1'b1;
      end else begin
        rv.exp_err = 1'b0;
        rv.exp_k = 5;
        rv.exp_bus = 1'b1;
        if (!rv.we) model_rdata = rv.di;
      end
      rv.exp_rdata = model_rdata;
      run_txn(rv, $sformatf("rnd%0d", i));
    end

    // Stale ack: ACK_N low at accept, released later; no strobe until it rises.
    resp_mode = 2;
    resp_di = 16'h5A5A;
    @(posedge clk);
    @(negedge clk);
    req = 1'b1;
    we = 1'b0;
    space = 2'd0;
    addr = 17'h00007;
    @(posedge clk);
    #1;
    req = 1'b0;
    seen = 1'b0;
    kk = -1;
    for (int c = 0; c < 40; c++) begin
      if (c <= 3) begin
        check($sformatf("stale strobes high c%0d", c), 32'({rd_n, lwr_n, uwr_n, reg_cs_n}), 32'hE);
      end
      if (c == 2) resp_mode = 0;
      if (done) begin
        seen = 1'b1;
        kk = c;
        check("stale err", 32'(err), 32'd0);
        break;
      end
      @(posedge clk);
      #1;
    end
    check("stale done latency", 32'(kk), 32'd8);
    check("stale rdata", 32'(rdata), 32'h5A5A);
    @(posedge clk);
    #1;

    // Reset in the middle of a read strobe.
    resp_di = 16'h7777;
    @(negedge clk);
    req = 1'b1;
    we = 1'b0;
    space = 2'd1;
    addr = 17'h00033;
    @(posedge clk);
    #1;
    req = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 10; c++) begin
      if (!rd_n) begin
        seen = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    check("rst strobe reached", 32'(seen), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("rst n_outputs", 32'({rd_n, lwr_n, uwr_n, reg_cs_n, dram_cs_n, pal_cs_n}), 32'h3F);
    check("rst busy/done", 32'({busy, done}), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    model_rdata = 16'h0;
    seen = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk);
      #1;
      if (done || busy) seen = 1'b1;
    end
    check("no done after rst", 32'(seen), 32'd0);
    check("rdata cleared by rst", 32'(rdata), 32'd0);
    rv = '{1'b0, 2'd0, 17'h00044, 16'h0, 2'b11, 16'h4321, 0, 1'b0, 16'h4321, 5, 1'b1};
    run_txn(rv, "post rst");
    model_rdata = 16'h4321;

    // REQ held high across DONE: the DONE cycle must not accept, the following one must.
    resp_di = 16'h9999;
    @(negedge clk);
    req = 1'b1;
    we = 1'b0;
    space = 2'd0;
    addr = 17'h00009;
    @(posedge clk);
    #1;
    seen = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (done) begin
        seen = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    check("held req done", 32'(seen), 32'd1);
    check("held req busy in done", 32'(busy), 32'd1);
    @(posedge clk);
    #1;
    check("held req idle gap", 32'(busy), 32'd0);
    @(posedge clk);
    #1;
    req = 1'b0;
    check("held req reaccept", 32'(busy), 32'd1);
    seen = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (done) begin
        seen = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    check("second done", 32'(seen), 32'd1);
    check("second rdata", 32'(rdata), 32'h9999);

    @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required $finish");
    $fatal(1);
  end

endmodule
